// File: rtl/rr_arbiter16_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
// Also used by rr_priority_encoder and other shared-resource controllers.
package arb_pkg;
    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_arbiter16_if.sv
// Requester-bank / datapath-select bundle of the round-robin arbiter.
// The arbiter takes the slave view; the requester side takes the master view.
interface rr_arbiter16_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] Req_In;
    logic               Done_In;
    logic [NUM_REQ-1:0] Grant_Out;
    logic [IDX_W-1:0]   Grant_Idx_Out;
    logic               Grant_Valid_Out;
    logic               Timeout_Out;

    modport master (
        output Req_In,
        output Done_In,
        input  Grant_Out,
        input  Grant_Idx_Out,
        input  Grant_Valid_Out,
        input  Timeout_Out
    );

    modport slave (
        input  Req_In,
        input  Done_In,
        output Grant_Out,
        output Grant_Idx_Out,
        output Grant_Valid_Out,
        output Timeout_Out
    );
endinterface

// File: rtl/rr_arbiter16_prio_enc.sv
// Combinational round-robin pick: lowest set request at or above Ptr,
// falling back to the lowest set request overall when nothing lies above Ptr.
module rr_priority_encoder
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] Req_In,
    input  logic [IDX_W-1:0]   Ptr,
    output logic [IDX_W-1:0]   Idx_Out,
    output logic               Valid_Out
);
    logic [NUM_REQ-1:0] mask_s;
    logic [NUM_REQ-1:0] masked_s;
    logic [IDX_W-1:0]   idx_masked_s;
    logic [IDX_W-1:0]   idx_unmasked_s;

    always_comb begin
        mask_s         = {NUM_REQ{1'b1}} << Ptr;
        masked_s       = Req_In & mask_s;
        idx_masked_s   = '0;
        idx_unmasked_s = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked_s[i]) idx_masked_s   = IDX_W'(i);
            if (Req_In[i])   idx_unmasked_s = IDX_W'(i);
        end
        Idx_Out   = (|masked_s) ? idx_masked_s : idx_unmasked_s;
        Valid_Out = |Req_In;
    end
endmodule

// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with registered one-hot and binary grant.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD hold-limit counter and Timeout_Out.
module rr_arbiter16
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic             Clk,
    input  logic             Rst_n,
    rr_arbiter16_if.slave    bus
);
    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vld_q, vld_d;

    logic [IDX_W-1:0]   enc_idx;
    logic               enc_vld;
    logic               release_s;
    logic               hold_exp_s;

    rr_priority_encoder u_enc (
        .Req_In    (bus.Req_In),
        .Ptr       (ptr_q),
        .Idx_Out   (enc_idx),
        .Valid_Out (enc_vld)
    );

    assign release_s = bus.Done_In || !bus.Req_In[idx_q];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    assign hold_exp_s = (cnt_q == CNT_W'(MAX_HOLD));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    // A normal release in the same cycle as expiry wins and suppresses the pulse.
    always_comb begin
        cnt_d = cnt_q;
        to_d  = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (release_s || hold_exp_s) begin
            cnt_d = '0;
            to_d  = hold_exp_s && !release_s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign bus.Timeout_Out = to_q;
`else
    assign hold_exp_s      = 1'b0;
    assign bus.Timeout_Out = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (enc_vld) begin
                    state_d = BUSY;
                    grant_d = NUM_REQ'(1) << enc_idx;
                    idx_d   = enc_idx;
                    vld_d   = 1'b1;
                    ptr_d   = enc_idx + 1'b1;
                end
            end
            BUSY: begin
                if (release_s || hold_exp_s) begin
                    state_d = IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Grant_Out       = grant_q;
    assign bus.Grant_Idx_Out   = idx_q;
    assign bus.Grant_Valid_Out = vld_q;
endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Round-robin arbiter sharing one downstream resource among 16 requesters. Each cycle it picks the next active request after the last winner, using a 16-to-4 priority encode, and holds a registered grant until the winner releases it. The grant is presented both one-hot and as a 4-bit binary index. It sits between the requester bank and the shared datapath and drives that datapath's select.

## Interface
- MAX_HOLD, default 15: maximum cycles one grant may be held when timeout is compiled in; legal range 1..255.
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Req_In  input  16  request vector, bit k = requester k; level-sensitive.
- Done_In  input  1  the current grant holder releases the resource; sampled only in BUSY.
- Grant_Out  output  16  one-hot grant, registered; all zero when no grant.
- Grant_Idx_Out  output  4  binary index of the granted requester, registered; 0 when no grant.
- Grant_Valid_Out  output  1  high while any grant is active.
- Timeout_Out  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- States: IDLE, BUSY.
- IDLE:
  - If Req_In is nonzero, register the winner and go to BUSY.
  - Winner = first set bit of Req_In searching upward from Ptr, wrapping 15 -> 0.
  - On that edge: Grant_Out = one-hot(winner), Grant_Idx_Out = winner, Grant_Valid_Out = 1, Ptr = winner+1 mod 16.
- BUSY, release conditions: Done_In = 1, OR Req_In[Grant_Idx_Out] = 0, OR the hold counter reaches MAX_HOLD (timeout build only).
- Release clears all grant outputs and returns to IDLE.
- Ptr resets to 0, so requester 0 has first priority after reset.
- Ptr update arithmetic is 4-bit modulo; 15+1 wraps to 0.
- Requests raised during BUSY are held off and do not preempt the grant.
- Simultaneous Done_In and timeout: treated as a normal release; Timeout_Out stays 0.
- Simultaneous release and a new request: the new request is arbitrated in the following IDLE cycle.
- Reset asserted mid-grant: all outputs clear immediately, with no clock required.
- Reset values: state IDLE, Ptr 0, hold counter 0, Grant_Out 0, Grant_Idx_Out 0, Grant_Valid_Out 0, Timeout_Out 0.

## Timing
- Request-to-grant latency: Req_In seen in IDLE before edge N gives the grant at edge N (1 cycle).
- Release: Done_In high before edge N clears Grant_* at edge N, and state is IDLE.
- The earliest next grant is at edge N+1, so there is always at least one idle cycle with Grant_Valid_Out = 0 between grants.
- Hold counter:
  - Clears to 0 on the grant edge and increments each BUSY cycle.
  - When the counter equals MAX_HOLD, the next edge revokes the grant and pulses Timeout_Out for that one cycle.
  - Maximum BUSY length is therefore MAX_HOLD+1 cycles.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- ARB_TIMEOUT_EN defined:
  - The hold counter (width $clog2(MAX_HOLD+1)) and the timeout release path are present.
  - Timeout_Out is driven as described above.
- ARB_TIMEOUT_EN undefined:
  - No counter is built.
  - The grant is held until Done_In or the winner's request drops.
  - Timeout_Out is tied 0.

## Structure
- Package arb_pkg holds:
  - NUM_REQ = 16 and IDX_W = 4.
  - The state enum (IDLE, BUSY).
- Sub-module rr_priority_encoder:
  - Combinational, with inputs Req_In[15:0] and Ptr[3:0]; outputs a 4-bit index and a valid flag.
  - Implemented as masked-then-unmasked priority search.
  - Reused by other shared-resource controllers.
- rr_arbiter16 holds the state register, Ptr, the hold counter and the output registers.

## Test plan
- Reset with Req_In = 16'hFFFF during reset, then release reset:
  - All outputs stay 0 until the first edge after reset.
  - Then Grant_Idx_Out = 0 and Grant_Out = 16'h0001.
- Round-robin with Req_In = 16'h8001 held and Done_In pulsed one cycle into each grant:
  - Grant sequence is 0, 15, 0, 15.
  - Each grant is separated by exactly one cycle with Grant_Valid_Out = 0.
- Wrap search: Ptr = 14 after granting 13, Req_In = 16'h0003 -> next grant is index 0, and Ptr becomes 1.
- Request drop: while index 5 is granted, deassert Req_In[5] -> Grant_Out = 0 on the next edge, with no Timeout_Out.
- Timeout with ARB_TIMEOUT_EN and MAX_HOLD = 3, Req_In[7] held, Done_In = 0:
  - Grant is valid for 4 cycles.
  - Timeout_Out pulses once, then index 7 is regranted after one idle cycle.
- Async reset mid-grant: assert Rst_n low between clock edges -> Grant_* and Timeout_Out clear immediately, and Ptr returns to 0.
